// File: rtl/matmul_host_ctrl_if.sv
// matmul_host_ctrl_if: operand (in_*) and result (out_*) streams between the
// bus/DMA fabric and the matmul host controller.
//
// Stream handshake, both directions: a beat transfers on a rising clk edge
// where valid && ready are both high. valid never waits on ready. data/last
// are held stable for as long as valid is high and ready is low.
interface matmul_host_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  // fabric side: produces operands, consumes results
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // controller side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/matmul_host_ctrl.sv
// matmul_host_ctrl: host-side sequencer for the matrix multiplication engine.
// Accepts a job, loads A then B row-major from the operand stream, programs
// the six operation registers, clears and kicks the engine, waits for its
// done handshake and streams C back out row-major.
// Optional feature: define MATMUL_HOST_TIMEOUT_EN to add a watchdog on the
// engine wait states (TIMEOUT cycles per wait state).
module matmul_host_ctrl #(
  parameter int DIM     = 15,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 8192
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4:0]        cfg_rows,
  input  logic [4:0]        cfg_inner,
  input  logic [4:0]        cfg_cols,
  input  logic [31:0]       cfg_op,
  output logic              busy,
  output logic              err,
  matmul_host_ctrl_if.slave bus,
  output logic              mm_clear,
  output logic              mm_enable,
  output logic [31:0]       mm_op [0:5],
  output logic [DATA_W-1:0] mm_a  [0:DIM-1][0:DIM-1],
  output logic [DATA_W-1:0] mm_b  [0:DIM-1][0:DIM-1],
  input  logic [DATA_W-1:0] mm_c  [0:DIM-1][0:DIM-1],
  input  logic              mm_done,
  output logic [2:0]        state_dbg
);

  localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD_A, S_LOAD_B, S_KICK, S_WAIT_LO, S_WAIT_HI, S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  rows_q, inner_q, cols_q;
  logic [4:0]  idx_i, idx_j;      // row / column of the element in flight
  logic [4:0]  lim_i, lim_j;
  logic [4:0]  ni, nj;
  logic        last_i, last_j, last_elem;
  logic        cfg_bad, accept, in_fire, out_fire, tmo_hit;
  logic        busy_d, in_ready_d, out_valid_d, mm_enable_d, mm_clear_d, err_d;

  assign state_dbg = state_q;

  assign cfg_bad = (cfg_rows == 5'd0)  || (cfg_rows > 5'(DIM))  ||
                   (cfg_inner == 5'd0) || (cfg_inner > 5'(DIM)) ||
                   (cfg_cols == 5'd0)  || (cfg_cols > 5'(DIM));
  assign accept   = (state_q == S_IDLE) && start && !cfg_bad;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  // Walk limits for the shared index pair: A is rows x inner, B is
  // inner x cols, C is rows x cols.
  always_comb begin
    lim_i = rows_q;
    lim_j = cols_q;
    case (state_q)
      S_LOAD_A: lim_j = inner_q;
      S_LOAD_B: lim_i = inner_q;
      default:  ;
    endcase
  end

  // Row-major successor of (idx_i, idx_j), wrapping at the limits.
  always_comb begin
    last_i    = (idx_i == lim_i - 5'd1);
    last_j    = (idx_j == lim_j - 5'd1);
    last_elem = last_i && last_j;
    nj        = last_j ? 5'd0 : idx_j + 5'd1;
    ni        = last_j ? (last_i ? 5'd0 : idx_i + 5'd1) : idx_i;
  end

`ifdef MATMUL_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  // Watchdog counter: restarts on every state change, counts in the wait states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tmo_cnt <= '0;
    else if (state_d != state_q)
      tmo_cnt <= '0;
    else if (state_q == S_WAIT_LO || state_q == S_WAIT_HI)
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state_q == S_WAIT_LO || state_q == S_WAIT_HI) &&
                   (tmo_cnt == TW'(TIMEOUT - 1));
`else
  // Watchdog compiled out: the engine wait is unbounded.
  assign tmo_hit = (TIMEOUT < 0);
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_CLEAR;
      S_CLEAR:   state_d = S_LOAD_A;
      S_LOAD_A:  if (in_fire && last_elem) state_d = S_LOAD_B;
      S_LOAD_B:  if (in_fire && last_elem) state_d = S_KICK;
      S_KICK:    state_d = S_WAIT_LO;
      S_WAIT_LO: if (tmo_hit) state_d = S_IDLE;
                 else if (!mm_done) state_d = S_WAIT_HI;
      S_WAIT_HI: if (tmo_hit) state_d = S_IDLE;
                 else if (mm_done) state_d = S_DRAIN;
      S_DRAIN:   if (out_fire && last_elem) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state, so every output is a flop that
  // lines up with the state it belongs to.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    in_ready_d  = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
    out_valid_d = (state_d == S_DRAIN);
    mm_enable_d = (state_d == S_KICK);
    mm_clear_d  = (state_d == S_CLEAR) || tmo_hit;
    err_d       = err;
    if (state_q == S_IDLE && start) err_d = cfg_bad;
    if (tmo_hit) err_d = 1'b1;
  end

  // Control output registers; the engine sees mm_clear throughout reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy          <= 1'b0;
      err           <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      mm_enable     <= 1'b0;
      mm_clear      <= 1'b1;
    end else begin
      busy          <= busy_d;
      err           <= err_d;
      bus.in_ready  <= in_ready_d;
      bus.out_valid <= out_valid_d;
      mm_enable     <= mm_enable_d;
      mm_clear      <= mm_clear_d;
    end
  end

  // Datapath: config latch, operand arrays, index walk and result beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_q       <= 5'd0;
      inner_q      <= 5'd0;
      cols_q       <= 5'd0;
      idx_i        <= 5'd0;
      idx_j        <= 5'd0;
      bus.out_data <= '0;
      bus.out_last <= 1'b0;
      for (int i = 0; i < 6; i++) mm_op[i] <= '0;
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM; j++) begin
          mm_a[i][j] <= '0;
          mm_b[i][j] <= '0;
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            rows_q   <= cfg_rows;
            inner_q  <= cfg_inner;
            cols_q   <= cfg_cols;
            idx_i    <= 5'd0;
            idx_j    <= 5'd0;
            mm_op[0] <= cfg_op;
            mm_op[1] <= {27'd0, cfg_rows};
            mm_op[2] <= {27'd0, cfg_inner};
            mm_op[3] <= {27'd0, cfg_inner};
            mm_op[4] <= {27'd0, cfg_cols};
            mm_op[5] <= 32'd1;
            // Elements outside the new extent must read as zero.
            for (int i = 0; i < DIM; i++) begin
              for (int j = 0; j < DIM; j++) begin
                mm_a[i][j] <= '0;
                mm_b[i][j] <= '0;
              end
            end
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (in_fire) begin
            if (state_q == S_LOAD_A) mm_a[idx_i[IW-1:0]][idx_j[IW-1:0]] <= bus.in_data;
            else                     mm_b[idx_i[IW-1:0]][idx_j[IW-1:0]] <= bus.in_data;
            idx_i <= ni;
            idx_j <= nj;
          end
        end
        S_WAIT_HI: begin
          if (state_d == S_DRAIN) begin
            idx_i        <= 5'd0;
            idx_j        <= 5'd0;
            bus.out_data <= mm_c[0][0];
            bus.out_last <= (rows_q == 5'd1) && (cols_q == 5'd1);
          end
        end
        S_DRAIN: begin
          if (out_fire) begin
            if (last_elem) begin
              bus.out_last <= 1'b0;
            end else begin
              idx_i        <= ni;
              idx_j        <= nj;
              bus.out_data <= mm_c[ni[IW-1:0]][nj[IW-1:0]];
              bus.out_last <= (ni == rows_q - 5'd1) && (nj == cols_q - 5'd1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_host_ctrl.sv
// tb_matmul_host_ctrl: randomized bench for matmul_host_ctrl with an engine
// model on the mm_* side and a row-major product model feeding an expected
// queue of result beats.
module tb_matmul_host_ctrl;
  localparam int DIM     = 15;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              start;
  logic [4:0]        cfg_rows, cfg_inner, cfg_cols;
  logic [31:0]       cfg_op;
  logic              busy, err, mm_clear, mm_enable, mm_done;
  logic [31:0]       mm_op [0:5];
  logic [DATA_W-1:0] mm_a  [0:DIM-1][0:DIM-1];
  logic [DATA_W-1:0] mm_b  [0:DIM-1][0:DIM-1];
  logic [DATA_W-1:0] mm_c  [0:DIM-1][0:DIM-1];
  logic [2:0]        state_dbg;

  matmul_host_ctrl_if #(.DATA_W(DATA_W)) bus_if ();

  matmul_host_ctrl #(.DIM(DIM), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_rows(cfg_rows), .cfg_inner(cfg_inner), .cfg_cols(cfg_cols), .cfg_op(cfg_op),
    .busy(busy), .err(err), .bus(bus_if),
    .mm_clear(mm_clear), .mm_enable(mm_enable), .mm_op(mm_op),
    .mm_a(mm_a), .mm_b(mm_b), .mm_c(mm_c), .mm_done(mm_done),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic              exp_last_q[$];
  logic [DATA_W-1:0] ja [0:DIM*DIM-1];
  logic [DATA_W-1:0] jb [0:DIM*DIM-1];
  int jr, jk, jc;
  int enable_cycles;
  int ready_mode;
  bit engine_stuck;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // C = A x B from the flat row-major operand lists of the current job.
  task automatic queue_expected();
    logic [DATA_W-1:0] s;
    for (int r = 0; r < jr; r++) begin
      for (int c = 0; c < jc; c++) begin
        s = '0;
        for (int k = 0; k < jk; k++) s += ja[r*jk+k] * jb[k*jc+c];
        exp_q.push_back(s);
        exp_last_q.push_back((r == jr-1) && (c == jc-1));
      end
    end
  endtask

  function automatic bit arrays_zero();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        if (mm_a[i][j] !== '0 || mm_b[i][j] !== '0) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- engine model ----------------
  function automatic logic [DATA_W-1:0] dot(input int i, input int j, input int nk);
    logic [DATA_W-1:0] s;
    s = '0;
    for (int k = 0; k < nk; k++) s += mm_a[i][k] * mm_b[k][j];
    return s;
  endfunction

  int eng_cnt;
  bit eng_busy;
  always @(posedge clk or posedge reset) begin
    int nr, nk, nc;
    if (reset) begin
      mm_done  <= 1'b1;
      eng_busy <= 1'b0;
      eng_cnt  <= 0;
      for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) mm_c[i][j] <= '0;
    end else begin
      nr = (mm_op[1] > DIM) ? DIM : int'(mm_op[1]);
      nk = (mm_op[2] > DIM) ? DIM : int'(mm_op[2]);
      nc = (mm_op[4] > DIM) ? DIM : int'(mm_op[4]);
      if (mm_clear) begin
        for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) mm_c[i][j] <= '0;
      end else if (mm_enable && !engine_stuck) begin
        for (int i = 0; i < nr; i++)
          for (int j = 0; j < nc; j++) mm_c[i][j] <= mm_c[i][j] + dot(i, j, nk);
        mm_done  <= 1'b0;
        eng_busy <= 1'b1;
        eng_cnt  <= $urandom_range(1, 6);
      end else if (eng_busy) begin
        if (eng_cnt == 0) begin
          mm_done  <= 1'b1;
          eng_busy <= 1'b0;
        end else begin
          eng_cnt <= eng_cnt - 1;
        end
      end
    end
  end

  // ---------------- out_ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus_if.out_ready = 1'b1;
      1:       bus_if.out_ready = ~bus_if.out_ready;
      default: bus_if.out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- compare process ----------------
  bit                hold_valid = 1'b0;
  logic [DATA_W-1:0] hold_data;
  logic              hold_last;
  always @(negedge clk) begin
    if (reset) begin
      hold_valid = 1'b0;
    end else begin
      if (mm_enable) enable_cycles++;
      if (hold_valid && bus_if.out_valid) begin
        check("stall_data", bus_if.out_data, hold_data);
        check("stall_last", bus_if.out_last, hold_last);
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          check("out_data", bus_if.out_data, exp_q.pop_front());
          check("out_last", bus_if.out_last, exp_last_q.pop_front());
        end
      end
      hold_valid = bus_if.out_valid && !bus_if.out_ready;
      hold_data  = bus_if.out_data;
      hold_last  = bus_if.out_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input int r, input int k, input int c, input logic [31:0] op);
    @(posedge clk); #1;
    cfg_rows = 5'(r); cfg_inner = 5'(k); cfg_cols = 5'(c); cfg_op = op;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_words(input bit which_b, input int n, input int gap_max);
    int budget;
    for (int i = 0; i < n; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = which_b ? jb[i] : ja[i];
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (!bus_if.in_ready && budget < 200);
      if (!bus_if.in_ready) begin
        check("in_ready_wait", 0, 1);
        bus_if.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      bus_if.in_valid = 1'b0;
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(posedge clk);
      if (gap_max > 0) #1;
    end
  endtask

  task automatic run_job(input int r, input int k, input int c, input logic [31:0] op,
                         input int gap_max);
    int budget;
    jr = r; jk = k; jc = c;
    queue_expected();
    enable_cycles = 0;
    do_start(r, k, c, op);
    check("accept_busy", busy, 1);
    check("accept_err", err, 0);
    check("accept_clear", mm_clear, 1);
    check("accept_zeroed", arrays_zero(), 1);
    send_words(1'b0, r*k, gap_max);
    send_words(1'b1, k*c, gap_max);
    budget = 0;
    while (busy && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    check("job_finished", busy, 0);
    check("beats_left", exp_q.size(), 0);
    check("enable_width", enable_cycles, 1);
    check("op0", mm_op[0], op);
    check("op1", mm_op[1], r);
    check("op2", mm_op[2], k);
    check("op3", mm_op[3], k);
    check("op4", mm_op[4], c);
    check("op5", mm_op[5], 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit saw_ready;
    engine_stuck     = 1'b0;
    ready_mode       = 0;
    enable_cycles    = 0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;
    cfg_rows = 5'd2; cfg_inner = 5'd2; cfg_cols = 5'd2; cfg_op = 32'h0;
    start = 1'b1;
    reset = 1'b1;

    // reset with start held high
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", bus_if.in_ready, 0);
    check("rst_out_valid", bus_if.out_valid, 0);
    check("rst_out_last", bus_if.out_last, 0);
    check("rst_enable", mm_enable, 0);
    check("rst_clear", mm_clear, 1);
    check("rst_op", mm_op[0] | mm_op[1] | mm_op[2] | mm_op[3] | mm_op[4] | mm_op[5], 0);
    check("rst_arrays", arrays_zero(), 1);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_clear", mm_clear, 0);
    check("post_rst_busy", busy, 0);

    // 2x2x2 directed job, with hand-computed results pinning the model
    ja[0] = 1; ja[1] = 2; ja[2] = 3; ja[3] = 4;
    jb[0] = 5; jb[1] = 6; jb[2] = 7; jb[3] = 8;
    jr = 2; jk = 2; jc = 2;
    queue_expected();
    check("pin_c00", exp_q[0], 19);
    check("pin_c01", exp_q[1], 22);
    check("pin_c10", exp_q[2], 43);
    check("pin_c11", exp_q[3], 50);
    check("pin_last", exp_last_q[3], 1);
    exp_q.delete();
    exp_last_q.delete();
    run_job(2, 2, 2, 32'h0000_00A5, 0);

    // 1x15x1, all ones: one beat of 15
    for (int i = 0; i < 15; i++) begin ja[i] = 1; jb[i] = 1; end
    jr = 1; jk = 15; jc = 1;
    queue_expected();
    check("pin_dot15", exp_q[0], 15);
    exp_q.delete();
    exp_last_q.delete();
    run_job(1, 15, 1, 32'h1234_5678, 0);
    check("pin_op_inner", mm_op[2], 15);

    // bad configurations
    do_start(2, 0, 2, 32'h1);
    check("bad_inner_err", err, 1);
    check("bad_inner_busy", busy, 0);
    saw_ready = 1'b0;
    repeat (4) begin @(negedge clk); saw_ready |= bus_if.in_ready; end
    check("bad_inner_ready", saw_ready, 0);
    do_start(16, 2, 2, 32'h1);
    check("bad_rows_err", err, 1);
    check("bad_rows_busy", busy, 0);
    saw_ready = 1'b0;
    repeat (4) begin @(negedge clk); saw_ready |= bus_if.in_ready; end
    check("bad_rows_ready", saw_ready, 0);

    // back-to-back 2x2x2 jobs with out_ready toggling
    ready_mode = 1;
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 4; i++) begin
        ja[i] = $urandom_range(0, 255);
        jb[i] = $urandom_range(0, 255);
      end
      run_job(2, 2, 2, 32'(n), 0);
    end

    // randomized jobs
    ready_mode = 2;
    for (int n = 0; n < 8; n++) begin
      int r, k, c;
      r = $urandom_range(1, 4);
      k = $urandom_range(1, (n == 7) ? 15 : 4);
      c = $urandom_range(1, 4);
      for (int i = 0; i < DIM*DIM; i++) begin ja[i] = $urandom(); jb[i] = $urandom(); end
      run_job(r, k, c, $urandom(), (n % 2) ? 2 : 0);
    end

    // reset in the middle of loading
    ready_mode = 0;
    for (int i = 0; i < 4; i++) begin ja[i] = i + 1; jb[i] = i + 1; end
    do_start(2, 2, 2, 32'h7);
    send_words(1'b0, 3, 0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_in_ready", bus_if.in_ready, 0);
    check("abort_out_valid", bus_if.out_valid, 0);
    check("abort_clear", mm_clear, 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_idle", busy, 0);

`ifdef MATMUL_HOST_TIMEOUT_EN
    begin
      int n;
      engine_stuck = 1'b1;
      ja[0] = 3; jb[0] = 4;
      do_start(1, 1, 1, 32'h9);
      send_words(1'b0, 1, 0);
      send_words(1'b1, 1, 0);
      n = 0;
      do begin @(negedge clk); n++; end while (!mm_enable && n < 100);
      check("tmo_kick", mm_enable, 1);
      n = 0;
      do begin @(negedge clk); n++; end while (!err && n < 100);
      check("tmo_cycles", n, 17);
      check("tmo_busy", busy, 0);
      check("tmo_clear", mm_clear, 1);
      check("tmo_out_valid", bus_if.out_valid, 0);
      engine_stuck = 1'b0;
      repeat (4) @(negedge clk);
    end
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global time limit
  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/matmul_host_ctrl.md
# matmul_host_ctrl

Host-side controller for the matrix multiplication engine. Accepts a job (dimensions plus an operand stream), loads the A and B operand arrays, and builds the six-word operation register set. It then clears and kicks the engine, waits for its `done` handshake, and streams the C result back out row-major. It sits between the bus/DMA fabric and the multiplier and owns every engine input except the clock.

## Interface
- `DIM`, default 15: matrix side capacity (engine arrays are `[0:DIM-1][0:DIM-1]`).
- `DATA_W`, default 32: element width.
- `TIMEOUT`, default 8192: watchdog limit in cycles; used only with `MATMUL_HOST_TIMEOUT_EN`.
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle job request; sampled only in IDLE.
- `cfg_rows`, `cfg_inner`, `cfg_cols`  in  5 each  C is rows×cols and the inner dimension is `cfg_inner`; each must be in 1..DIM.
- `cfg_op`  in  32  operation code, copied to `mm_op[0]`.
- `busy`  out  1  high from accepted start until the last output beat.
- `err`  out  1  sticky until next accepted start; set on a bad config or a timeout.
- `in_valid`  in  1, `in_ready`  out  1, `in_data`  in  DATA_W  operand stream.
- `out_valid`  out  1, `out_ready`  in  1, `out_data`  out  DATA_W, `out_last`  out  1  result stream.
- `mm_clear`  out  1  synchronous reset pulse to the engine.
- `mm_enable`  out  1  engine start pulse.
- `mm_op`  out  32×6  engine operation registers.
- `mm_a`, `mm_b`  out  DATA_W×DIM×DIM  operand arrays.
- `mm_c`  in  DATA_W×DIM×DIM  engine result array.
- `mm_done`  in  1  engine done flag; reads 1 when the engine is idle.

## Operation
- States: IDLE, CLEAR, LOAD_A, LOAD_B, KICK, WAIT_LO, WAIT_HI, DRAIN.
- IDLE:
  - On `start`, if any dimension is 0 or greater than DIM: set `err`, stay in IDLE, `busy` stays 0.
  - Otherwise latch the config, clear `err`, zero `mm_a`/`mm_b`, and go to CLEAR.
- CLEAR: `mm_clear`=1 for exactly one cycle, which zeroes the engine accumulators. Then go to LOAD_A.
- LOAD_A: `in_ready`=1. Each beat with `in_valid && in_ready` writes `mm_a[r][k]`, row-major, r<rows, k<inner. After rows·inner beats go to LOAD_B.
- LOAD_B: same handshake, writing `mm_b[k][c]` row-major, k<inner, c<cols. After inner·cols beats go to KICK.
- `mm_op` mapping (held stable from KICK through WAIT_HI):
  - `[0]`=cfg_op
  - `[1]`=rows
  - `[2]`=inner
  - `[3]`=inner
  - `[4]`=cols
  - `[5]`=1
- KICK: `mm_enable`=1 for one cycle, then go to WAIT_LO.
- WAIT_LO: wait for `mm_done`=0 (engine accepted the job), then go to WAIT_HI.
- WAIT_HI: wait for `mm_done`=1, then go to DRAIN.
- DRAIN: present `mm_c[r][c]` row-major. Advance on `out_valid && out_ready`. `out_last`=1 on beat rows·cols−1. After the last beat, return to IDLE with `busy`=0.
- Index counters are 5 bits each and wrap to 0 at their dimension limit. Elements outside the loaded extent stay 0.
- `start` while busy is ignored.

## Timing
- Reset values:
  - state=IDLE
  - `busy`, `err`, `in_ready`, `out_valid`, `out_last`, `mm_enable`=0
  - `mm_clear`=1 while `reset` is asserted, then 0
  - `mm_op`, `mm_a`, `mm_b`=0
- Reset mid-job: abort immediately, with no further output beats.
- All outputs are registered.
- Job latency:
  - start→CLEAR: 1 cycle.
  - Loading: 1 cycle per operand beat, with no bubbles under continuous `in_valid`.
  - KICK→WAIT_LO: 1 cycle.
  - Engine compute time is external.
  - WAIT_HI→first `out_valid`: 1 cycle.
- `out_data`/`out_last` stay stable while `out_valid && !out_ready`.
- Output throughput is 1 beat/cycle.
- `in_ready` is 0 outside LOAD_A/LOAD_B. A beat presented in any other state is not consumed.

## Configuration
- `MATMUL_HOST_TIMEOUT_EN` defined:
  - A counter runs in WAIT_LO/WAIT_HI and resets on each state entry.
  - At TIMEOUT cycles: set `err`, pulse `mm_clear`, go to IDLE, `busy`=0, no output beats.
- Not defined: no counter; the controller waits indefinitely for `mm_done`.

## Test plan
- Reset with `start` held high → all outputs at their reset values; after release, one `start` with a 2×2×2 config is accepted one cycle later.
- Dims 2/2/2, A={1,2,3,4}, B={5,6,7,8}, engine model attached → out beats 19,22,43,50; `out_last` on the 4th beat; `mm_enable` high exactly 1 cycle.
- Dims 1/15/1, all operands 1 → a single beat of 15 with `out_last`=1; `mm_op`={op,1,15,15,1,1}.
- `cfg_inner`=0 or `cfg_rows`=16 → `err`=1, `busy`=0, `in_ready` never asserts.
- Two back-to-back 2×2 jobs with `out_ready` toggling every other cycle → the second result is not accumulated onto the first (`mm_clear` between jobs); data held stable during stalls.
- With `MATMUL_HOST_TIMEOUT_EN` and TIMEOUT=16, `mm_done` stuck at 1 → `err`=1 at WAIT_LO entry + 16, return to IDLE with no output beats.
